pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (ALU result, store data, branch target).
REQ-002 Parameter CTRL_W, default 5, width of the control field (Branch, MemRead, MemWrite, RegWrite, MemtoReg, ...).
REQ-003 Parameter CNT_W, default 8, width of the stall counter.
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 in_valid_i  input  1  upstream stage presents an instruction.
REQ-007 in_ready_o  output  1  stage can accept; SHALL equal NOT skid_valid and be driven directly from a register.
REQ-008 in_data_i  input  DATA_W  upstream payload.
REQ-009 in_ctrl_i  input  CTRL_W  upstream control field.
REQ-010 out_valid_o  output  1  main register holds a valid instruction.
REQ-011 out_ready_i  input  1  downstream stage accepts.
REQ-012 out_data_o  output  DATA_W  main register payload.
REQ-013 out_ctrl_o  output  CTRL_W  main register control field; all-zero whenever out_valid_o=0 (bubble).
REQ-014 flush_i  input  1  synchronous squash of all held instructions.
REQ-015 cnt_clr_i  input  1  synchronous clear of stall counter.
REQ-016 stall_cnt_o  output  CNT_W  count of back-pressured cycles.
REQ-017 occupancy_o  output  2  held entries, 0..2.

Function
REQ-018 Storage: one main entry (drives outputs) and one skid entry, each holding valid, data, ctrl.
REQ-019 Accept = in_valid_i AND in_ready_o; send = out_valid_o AND out_ready_i.
REQ-020 Skid empty, main empty or send, accept: the incoming entry SHALL load main.
REQ-021 Skid empty, main full, no send, accept: the incoming entry SHALL load skid; in_ready_o SHALL go 0 the next cycle.
REQ-022 Skid full and send: skid SHALL move to main and skid SHALL empty; no accept is possible that cycle.
REQ-023 Send without accept or skid: main valid SHALL clear and main ctrl SHALL be zeroed.
REQ-024 Latency accept to out_valid_o SHALL be exactly 1 cycle when the stage is empty.
REQ-025 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-026 No combinational path in_valid_i->out_valid_o or out_ready_i->in_ready_o.
REQ-027 flush_i SHALL take priority over everything else: both valids clear and both ctrl fields zero at the next edge; an entry accepted in the same cycle is discarded; the data fields are don't-care.
REQ-028 Stall counter SHALL increment when out_valid_o=1 and out_ready_i=0, and saturate at 2^CNT_W-1.
REQ-029 cnt_clr_i SHALL zero the counter and override increment; flush_i SHALL NOT affect the counter.
REQ-030 occupancy_o SHALL equal main_valid + skid_valid, registered.
REQ-031 Holding main with out_ready_i=0 SHALL keep out_data_o and out_ctrl_o stable.

Reset
REQ-032 rst_i=1 SHALL immediately force: out_valid_o=0, out_data_o=0, out_ctrl_o=0, skid cleared, in_ready_o=1, stall_cnt_o=0, occupancy_o=0.
REQ-033 Inputs SHALL be ignored while rst_i=1.
REQ-034 Reset asserted mid-operation SHALL discard all held entries with no partial output.
REQ-035 The first accept SHALL be possible on the first rising edge after rst_i deasserts.

Verification (DATA_W=32, CTRL_W=5, CNT_W=8)
REQ-036 Pass-through: out_ready_i=1, stream data 0x1,0x2,0x3 with ctrl 5'b10110 -> outputs appear one cycle later, in order, occupancy_o never above 1.
REQ-037 Skid: main holds 0xA, out_ready_i=0, accept 0xB -> in_ready_o=0, occupancy_o=2; raise out_ready_i -> 0xA then 0xB on consecutive cycles, in_ready_o=1 after 0xA leaves.
REQ-038 Flush: occupancy 2 plus a simultaneous accept of 0xC with flush_i=1 -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0; 0xC never appears.
REQ-039 Stall counter: hold out_ready_i=0 with a valid entry for 300 cycles -> stall_cnt_o=255; pulse cnt_clr_i -> 0; assert flush_i while counting -> count continues unchanged.
REQ-040 Async reset: assert rst_i between clock edges at occupancy 2 -> outputs go to the REQ-032 values before the next edge; accept 0x5 on the first edge after release -> out_valid_o=1 with 0x5.
REQ-041 Random: random in_valid_i and out_ready_i for 10k cycles, scoreboard -> order preserved, no loss or duplication, out_ctrl_o=0 whenever out_valid_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: one main entry driving the outputs plus one skid entry,
// so that in_ready_o comes straight from a flop with no path from out_ready_i.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [1:0]        occupancy_o
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [1:0]        r_occ;

    logic              w_accept;
    logic              w_send;
    logic              w_main_valid_next;
    logic [DATA_W-1:0] w_main_data_next;
    logic [CTRL_W-1:0] w_main_ctrl_next;
    logic              w_skid_valid_next;
    logic [DATA_W-1:0] w_skid_data_next;
    logic [CTRL_W-1:0] w_skid_ctrl_next;
    logic [CNT_W-1:0]  w_stall_cnt_next;

    assign w_accept = in_valid_i & r_in_ready;
    assign w_send   = r_main_valid & out_ready_i;

    always_comb begin
        w_main_valid_next = r_main_valid;
        w_main_data_next  = r_main_data;
        w_main_ctrl_next  = r_main_ctrl;
        w_skid_valid_next = r_skid_valid;
        w_skid_data_next  = r_skid_data;
        w_skid_ctrl_next  = r_skid_ctrl;

        if (flush_i) begin
            w_main_valid_next = 1'b0;
            w_main_ctrl_next  = '0;
            w_skid_valid_next = 1'b0;
            w_skid_ctrl_next  = '0;
        end else if (r_skid_valid) begin
            // Skid full means in_ready is low, so only a drain into main can happen.
            if (w_send) begin
                w_main_valid_next = 1'b1;
                w_main_data_next  = r_skid_data;
                w_main_ctrl_next  = r_skid_ctrl;
                w_skid_valid_next = 1'b0;
                w_skid_ctrl_next  = '0;
            end
        end else if (w_accept && (!r_main_valid || w_send)) begin
            w_main_valid_next = 1'b1;
            w_main_data_next  = in_data_i;
            w_main_ctrl_next  = in_ctrl_i;
        end else if (w_accept) begin
            w_skid_valid_next = 1'b1;
            w_skid_data_next  = in_data_i;
            w_skid_ctrl_next  = in_ctrl_i;
        end else if (w_send) begin
            w_main_valid_next = 1'b0;
            w_main_ctrl_next  = '0;
        end
    end

    always_comb begin
        w_stall_cnt_next = r_stall_cnt;
        if (cnt_clr_i) begin
            w_stall_cnt_next = '0;
        end else if (r_main_valid && !out_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_next = r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_in_ready   <= 1'b1;
            r_stall_cnt  <= '0;
            r_occ        <= 2'd0;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_main_data  <= w_main_data_next;
            r_main_ctrl  <= w_main_ctrl_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_data  <= w_skid_data_next;
            r_skid_ctrl  <= w_skid_ctrl_next;
            r_in_ready   <= ~w_skid_valid_next;
            r_stall_cnt  <= w_stall_cnt_next;
            r_occ        <= {1'b0, w_main_valid_next} + {1'b0, w_skid_valid_next};
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_main_valid;
    assign out_data_o  = r_main_data;
    assign out_ctrl_o  = r_main_ctrl;
    assign stall_cnt_o = r_stall_cnt;
    assign occupancy_o = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg with a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 5;
    localparam int CNT_W  = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic              flush_i;
    logic              cnt_clr_i;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [1:0]        occupancy_o;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ctrl_i   (in_ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ctrl_o  (out_ctrl_o),
        .flush_i     (flush_i),
        .cnt_clr_i   (cnt_clr_i),
        .stall_cnt_o (stall_cnt_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hDEAD; in_ctrl_i = 5'h1F;
        out_ready_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
        tick(); tick();
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        n_vec++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data_o); end
        n_vec++; if (out_ctrl_o !== 5'h0) begin n_err++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl_o); end
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
        n_vec++; if (stall_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o); end
        n_vec++; if (occupancy_o !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
        rst_i = 1'b0; in_valid_i = 1'b0;
        tick();
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid_o); end
    endtask

    task automatic test_pass_through();
        logic [31:0] vals [3];
        vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
        out_ready_i = 1'b1; in_ctrl_i = 5'b10110;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = vals[i];
            tick();
            n_vec++;
            if (out_valid_o !== 1'b1 || out_data_o !== vals[i] || out_ctrl_o !== 5'b10110 || occupancy_o !== 2'd1) begin
                n_err++;
                $display("FAIL pass_%0d got v=%b d=%h c=%b occ=%0d exp v=1 d=%h c=10110 occ=1",
                         i, out_valid_o, out_data_o, out_ctrl_o, occupancy_o, vals[i]);
            end
        end
        in_valid_i = 1'b0;
        tick();
        n_vec++;
        if (out_valid_o !== 1'b0 || out_ctrl_o !== 5'h0 || occupancy_o !== 2'd0) begin
            n_err++;
            $display("FAIL pass_drain got v=%b c=%b occ=%0d exp v=0 c=0 occ=0", out_valid_o, out_ctrl_o, occupancy_o);
        end
    endtask

    task automatic test_skid();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'hA; in_ctrl_i = 5'h0A;
        tick();
        n_vec++; if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL skid_load_a got occ=%0d rdy=%b exp occ=1 rdy=1", occupancy_o, in_ready_o); end
        in_data_i = 32'hB; in_ctrl_i = 5'h0B;
        tick();
        in_valid_i = 1'b0;
        n_vec++;
        if (in_ready_o !== 1'b0 || occupancy_o !== 2'd2 || out_data_o !== 32'hA || out_ctrl_o !== 5'h0A) begin
            n_err++;
            $display("FAIL skid_full got rdy=%b occ=%0d d=%h c=%h exp rdy=0 occ=2 d=a c=0a", in_ready_o, occupancy_o, out_data_o, out_ctrl_o);
        end
        tick();
        n_vec++; if (out_data_o !== 32'hA || occupancy_o !== 2'd2) begin n_err++; $display("FAIL skid_hold got d=%h occ=%0d exp d=a occ=2", out_data_o, occupancy_o); end
        out_ready_i = 1'b1;
        tick();
        n_vec++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hB || out_ctrl_o !== 5'h0B || in_ready_o !== 1'b1 || occupancy_o !== 2'd1) begin
            n_err++;
            $display("FAIL skid_second got v=%b d=%h c=%h rdy=%b occ=%0d exp v=1 d=b c=0b rdy=1 occ=1",
                     out_valid_o, out_data_o, out_ctrl_o, in_ready_o, occupancy_o);
        end
        tick();
        n_vec++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_err++; $display("FAIL skid_empty got v=%b occ=%0d exp v=0 occ=0", out_valid_o, occupancy_o); end
    endtask

    task automatic test_flush();
        // Flush with both entries held while upstream offers 0xC.
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_ctrl_i = 5'h03;
        in_data_i = 32'h1A; tick();
        in_data_i = 32'h1B; tick();
        n_vec++; if (occupancy_o !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy_o); end
        in_data_i = 32'hC; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_vec++;
        if (out_valid_o !== 1'b0 || out_ctrl_o !== 5'h0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full got v=%b c=%h occ=%0d rdy=%b exp v=0 c=0 occ=0 rdy=1", out_valid_o, out_ctrl_o, occupancy_o, in_ready_o);
        end
        // One held entry and an actual accept of 0xC in the flush cycle.
        in_data_i = 32'h2A; tick();
        in_data_i = 32'hC; flush_i = 1'b1;
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_accept_rdy got=%b exp=1", in_ready_o); end
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        n_vec++;
        if (out_valid_o !== 1'b0 || out_ctrl_o !== 5'h0 || occupancy_o !== 2'd0) begin
            n_err++;
            $display("FAIL flush_accept got v=%b c=%h occ=%0d exp v=0 c=0 occ=0", out_valid_o, out_ctrl_o, occupancy_o);
        end
        tick();
        n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_c got v=%b d=%h exp v=0", out_valid_o, out_data_o); end
    endtask

    task automatic test_stall_cnt();
        out_ready_i = 1'b0; cnt_clr_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h7; in_ctrl_i = 5'h01;
        tick();
        cnt_clr_i = 1'b0; in_valid_i = 1'b0;
        n_vec++; if (stall_cnt_o !== 8'd0) begin n_err++; $display("FAIL cnt_start got=%0d exp=0", stall_cnt_o); end
        repeat (10) tick();
        n_vec++; if (stall_cnt_o !== 8'd10) begin n_err++; $display("FAIL cnt_10 got=%0d exp=10", stall_cnt_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_vec++; if (stall_cnt_o !== 8'd11) begin n_err++; $display("FAIL cnt_flush got=%0d exp=11", stall_cnt_o); end
        tick();
        n_vec++; if (stall_cnt_o !== 8'd11) begin n_err++; $display("FAIL cnt_idle got=%0d exp=11", stall_cnt_o); end
        in_valid_i = 1'b1; in_data_i = 32'h8;
        tick();
        in_valid_i = 1'b0;
        repeat (300) tick();
        n_vec++; if (stall_cnt_o !== 8'd255) begin n_err++; $display("FAIL cnt_sat got=%0d exp=255", stall_cnt_o); end
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        n_vec++; if (stall_cnt_o !== 8'd0) begin n_err++; $display("FAIL cnt_clr got=%0d exp=0", stall_cnt_o); end
        tick();
        n_vec++; if (stall_cnt_o !== 8'd1) begin n_err++; $display("FAIL cnt_resume got=%0d exp=1", stall_cnt_o); end
        out_ready_i = 1'b1;
        tick();
        n_vec++; if (stall_cnt_o !== 8'd1 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL cnt_drain got cnt=%0d v=%b exp cnt=1 v=0", stall_cnt_o, out_valid_o); end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0; in_valid_i = 1'b1; in_ctrl_i = 5'h11;
        in_data_i = 32'h31; tick();
        in_data_i = 32'h32; tick();
        n_vec++; if (occupancy_o !== 2'd2) begin n_err++; $display("FAIL arst_pre_occ got=%0d exp=2", occupancy_o); end
        #2 rst_i = 1'b1;
        #1;
        n_vec++;
        if (out_valid_o !== 1'b0 || out_data_o !== 32'h0 || out_ctrl_o !== 5'h0 || in_ready_o !== 1'b1
            || stall_cnt_o !== 8'd0 || occupancy_o !== 2'd0) begin
            n_err++;
            $display("FAIL arst_immediate got v=%b d=%h c=%h rdy=%b cnt=%0d occ=%0d exp all 0 rdy=1",
                     out_valid_o, out_data_o, out_ctrl_o, in_ready_o, stall_cnt_o, occupancy_o);
        end
        tick();
        n_vec++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin n_err++; $display("FAIL arst_ignore got v=%b occ=%0d exp v=0 occ=0", out_valid_o, occupancy_o); end
        #3 rst_i = 1'b0;
        in_data_i = 32'h5; in_ctrl_i = 5'h05; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n_vec++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h5 || out_ctrl_o !== 5'h05) begin
            n_err++;
            $display("FAIL arst_first_accept got v=%b d=%h c=%h exp v=1 d=5 c=05", out_valid_o, out_data_o, out_ctrl_o);
        end
        tick();
    endtask

    task automatic test_random();
        logic [36:0] q[$];
        logic [31:0] seq;
        logic        send;
        logic        acc;
        seq = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            n_vec++;
            if (occupancy_o !== 2'(q.size()) || out_valid_o !== (q.size() > 0) || in_ready_o !== (q.size() < 2)) begin
                n_err++;
                $display("FAIL rand_state cyc=%0d got occ=%0d v=%b rdy=%b exp occ=%0d", i, occupancy_o, out_valid_o, in_ready_o, q.size());
            end
            if (q.size() > 0) begin
                n_vec++;
                if ({out_ctrl_o, out_data_o} !== q[0]) begin
                    n_err++;
                    $display("FAIL rand_data cyc=%0d got %h exp %h", i, {out_ctrl_o, out_data_o}, q[0]);
                end
            end else begin
                n_vec++;
                if (out_ctrl_o !== 5'h0) begin n_err++; $display("FAIL rand_bubble cyc=%0d got c=%h exp 0", i, out_ctrl_o); end
            end
            in_valid_i  = 1'($urandom_range(0, 1));
            out_ready_i = ($urandom_range(0, 3) != 0);
            in_data_i   = seq;
            in_ctrl_i   = 5'($urandom_range(1, 31));
            send = (q.size() > 0) && out_ready_i;
            acc  = in_valid_i && (q.size() < 2);
            if (send) void'(q.pop_front());
            if (acc) begin
                q.push_back({in_ctrl_i, in_data_i});
                seq++;
            end
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_skid();
        test_flush();
        test_stall_cnt();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
